uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/loader_pkg.sv | 32 +++
 rtl/byte_packer.sv | 42 ++++
 rtl/uart_loader.sv | 201 ++++++++++++++++++++
 tb/tb_uart_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the UART boot loader.
// The CHK state exists only when UART_LOADER_CHKSUM_EN is defined.
package loader_pkg;

    typedef logic [31:0] word_t;

    localparam logic [7:0] ACK_OK_DEFAULT  = 8'hAA;
    localparam logic [7:0] ACK_ERR_DEFAULT = 8'h55;

`ifdef UART_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_LOAD = 3'd1,
        ST_CHK  = 3'd2,
        ST_ACK  = 3'd3,
        ST_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_LOAD = 3'd1,
        ST_ACK  = 3'd3,
        ST_DONE = 3'd4
    } state_t;
`endif

    // Running XOR over the payload bytes
    function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-byte word assembler with a wrapping 2-bit lane counter.
// The completed word is presented combinationally in the cycle of its 4th byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       word_last,
    output word_t      word
);

    logic [1:0]  lane_r;
    logic [23:0] low_r;

    // Lane 3 completes the word; the incoming byte forms bits [31:24] directly
    always_comb begin
        word_last = byte_valid && (lane_r == 2'd3);
        word      = {byte_data, low_r};
    end

    // Lane counter and lower-lane holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_r <= 2'd0;
            low_r  <= 24'd0;
        end else if (byte_valid) begin
            lane_r <= lane_r + 2'd1;
            case (lane_r)
                2'd0:    low_r[7:0]   <= byte_data;
                2'd1:    low_r[15:8]  <= byte_data;
                2'd2:    low_r[23:16] <= byte_data;
                default: low_r        <= low_r;
            endcase
        end else begin
            lane_r <= lane_r;
            low_r  <= low_r;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: word count N, then N little-endian words into instruction memory, then ACK.
// Define UART_LOADER_CHKSUM_EN to add a trailing XOR checksum byte check (CHK state).
module uart_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 14,
    parameter logic [7:0]  ACK_OK  = ACK_OK_DEFAULT,
    parameter logic [7:0]  ACK_ERR = ACK_ERR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_ferr,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              load_done,
    output logic              load_err
);

    state_t            state_r;
    state_t            state_s;
    word_t             n_r;
    word_t             n_s;
    word_t             wcnt_r;
    word_t             wcnt_s;
    logic              rx_phase_s;
    logic              accept_s;
    logic              ferr_s;
    logic              word_last_s;
    word_t             word_s;
    logic              err_s;
    logic              we_s;
    logic [ADDR_W-1:0] addr_s;
    logic [31:0]       wdata_s;
    logic              tx_start_s;
    logic [7:0]        tx_data_s;
    logic              done_s;
`ifdef UART_LOADER_CHKSUM_EN
    logic [7:0]        xor_r;
    logic [7:0]        xor_s;
`endif

    // Classify the incoming byte: framing errors are dropped but flagged while receiving
    always_comb begin
`ifdef UART_LOADER_CHKSUM_EN
        rx_phase_s = (state_r == ST_HDR) || (state_r == ST_LOAD) || (state_r == ST_CHK);
`else
        rx_phase_s = (state_r == ST_HDR) || (state_r == ST_LOAD);
`endif
        accept_s = rx_valid && !rx_ferr && ((state_r == ST_HDR) || (state_r == ST_LOAD));
        ferr_s   = rx_valid && rx_ferr && rx_phase_s;
    end

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (accept_s),
        .byte_data  (rx_data),
        .word_last  (word_last_s),
        .word       (word_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_s    = state_r;
        n_s        = n_r;
        wcnt_s     = wcnt_r;
        err_s      = load_err || ferr_s;
        we_s       = 1'b0;
        addr_s     = imem_addr;
        wdata_s    = imem_wdata;
        tx_start_s = 1'b0;
        tx_data_s  = tx_data;
        done_s     = load_done;
`ifdef UART_LOADER_CHKSUM_EN
        xor_s      = xor_r;
`endif
        case (state_r)
            ST_HDR: begin
                if (word_last_s) begin
                    n_s = word_s;
                    if (word_s == 32'd0) begin
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_LOAD: begin
`ifdef UART_LOADER_CHKSUM_EN
                if (accept_s) begin
                    xor_s = xor_accum(xor_r, rx_data);
                end else begin
                    xor_s = xor_r;
                end
`endif
                if (word_last_s) begin
                    wcnt_s = wcnt_r + 32'd1;
                    // Indices past the memory are consumed but never written: no address wrap
                    if ((wcnt_r >> ADDR_W) == 32'd0) begin
                        we_s    = 1'b1;
                        addr_s  = wcnt_r[ADDR_W-1:0];
                        wdata_s = word_s;
                    end else begin
                        err_s = 1'b1;
                    end
                    if ((wcnt_r + 32'd1) == n_r) begin
`ifdef UART_LOADER_CHKSUM_EN
                        state_s = ST_CHK;
`else
                        state_s = ST_ACK;
`endif
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
`ifdef UART_LOADER_CHKSUM_EN
            ST_CHK: begin
                if (rx_valid && !rx_ferr) begin
                    if (rx_data != xor_r) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = load_err;
                    end
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_CHK;
                end
            end
`endif
            ST_ACK: begin
                if (!tx_busy) begin
                    tx_start_s = 1'b1;
                    tx_data_s  = load_err ? ACK_ERR : ACK_OK;
                    done_s     = 1'b1;
                    state_s    = ST_DONE;
                end else begin
                    state_s = ST_ACK;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
                done_s  = 1'b1;
            end
            default: begin
                state_s = ST_HDR;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_HDR;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            n_r        <= 32'd0;
            wcnt_r     <= 32'd0;
            imem_we    <= 1'b0;
            imem_addr  <= {ADDR_W{1'b0}};
            imem_wdata <= 32'd0;
            tx_start   <= 1'b0;
            tx_data    <= 8'd0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef UART_LOADER_CHKSUM_EN
            xor_r      <= 8'd0;
`endif
        end else begin
            n_r        <= n_s;
            wcnt_r     <= wcnt_s;
            imem_we    <= we_s;
            imem_addr  <= addr_s;
            imem_wdata <= wdata_s;
            tx_start   <= tx_start_s;
            tx_data    <= tx_data_s;
            load_done  <= done_s;
            load_err   <= err_s;
`ifdef UART_LOADER_CHKSUM_EN
            xor_r      <= xor_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized self-checking bench for uart_loader with a queue-based protocol model.
// Honors UART_LOADER_CHKSUM_EN to append and check the payload checksum byte.
module tb_uart_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ferr = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          load_done;
    logic          load_err;

    uart_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ferr    (rx_ferr),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        bit          f;
        bit          wr;
        int          addr;
        logic [31:0] wd;
    } ent_t;

    typedef struct {
        int          addr;
        logic [31:0] wd;
        int          cyc;
    } wr_t;

    ent_t        stream[$];
    wr_t         expq[$];
    logic [31:0] wd[16];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          tx_cnt = 0;
    int          first_addr = -1;
    int          last_addr = -1;
    logic [31:0] first_wdata = 32'd0;
    logic [31:0] last_wdata = 32'd0;
    logic [7:0]  last_tx = 8'd0;
    logic [7:0]  exp_ack = 8'hAA;
    bit          exp_err = 1'b0;
    bit          prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: every write against the model queue, ACK byte and done flag every cycle
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (imem_we) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_we got addr=%0d data=%h required no write", imem_addr, imem_wdata);
                end else begin
                    e = expq.pop_front();
                    check("we_addr", 32'(imem_addr), e.addr);
                    check("we_data", imem_wdata, e.wd);
                    check("we_cycle", cyc, e.cyc);
                end
                if (wr_cnt == 0) begin
                    first_addr  = int'(imem_addr);
                    first_wdata = imem_wdata;
                end
                wr_cnt++;
                last_addr  = int'(imem_addr);
                last_wdata = imem_wdata;
            end
            if (tx_start) begin
                check("tx_once", tx_cnt, 0);
                check("tx_not_busy", 32'(prev_busy), 0);
                check("tx_byte", 32'(tx_data), 32'(exp_ack));
                tx_cnt++;
                last_tx = tx_data;
            end
            check("done_flag", 32'(load_done), 32'(tx_cnt > 0));
            prev_busy = tx_busy;
            if (rst) begin
                wr_cnt = 0;
                tx_cnt = 0;
                first_addr = -1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_ferr = 1'b0;
        tx_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_load_err", 32'(load_err), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_pending_wr", expq.size(), 0);
        expq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Model: byte stream plus expected writes/err/ack from the protocol rules
    task automatic build(input int n, input int ferr_cnt, input int ferr_pos, input logic [7:0] cs_xor);
        ent_t        e;
        logic [7:0]  cs;
        logic [31:0] nw;
        bit          chk_err;
        int          pos;
        stream.delete();
        cs = 8'h00;
        nw = n;
        chk_err = 1'b0;
        for (int b = 0; b < 4; b++) begin
            e.d = nw[8*b +: 8]; e.f = 1'b0; e.wr = 1'b0; e.addr = 0; e.wd = 32'd0;
            stream.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                e.d = wd[i][8*b +: 8];
                cs = cs ^ e.d;
                e.f = 1'b0;
                e.wr = (b == 3) && (i < (1 << AW));
                e.addr = i;
                e.wd = wd[i];
                stream.push_back(e);
            end
        end
`ifdef UART_LOADER_CHKSUM_EN
        if (n != 0) begin
            e.d = cs ^ cs_xor; e.f = 1'b0; e.wr = 1'b0; e.addr = 0; e.wd = 32'd0;
            stream.push_back(e);
            chk_err = (cs_xor != 8'h00);
        end
`endif
        for (int k = 0; k < ferr_cnt; k++) begin
            e.d = 8'($urandom); e.f = 1'b1; e.wr = 1'b0; e.addr = 0; e.wd = 32'd0;
            pos = (ferr_pos >= 0) ? ferr_pos : int'($urandom_range(0, stream.size() - 1));
            stream.insert(pos, e);
        end
        exp_err = (ferr_cnt > 0) || (n > (1 << AW)) || chk_err;
        exp_ack = exp_err ? 8'h55 : 8'hAA;
    endtask

    task automatic send_stream();
        ent_t e;
        wr_t  w;
        while (stream.size() > 0) begin
            e = stream.pop_front();
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                    rx_valid = 1'b0;
                    rx_ferr = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            rx_valid = 1'b1;
            rx_data = e.d;
            rx_ferr = e.f;
            if (e.wr) begin
                w.addr = e.addr;
                w.wd = e.wd;
                w.cyc = cyc + 1;
                expq.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_ferr = 1'b0;
    endtask

    task automatic run_load(input int n, input int ferr_cnt, input int ferr_pos,
                            input logic [7:0] cs_xor, input int stop_words);
        ent_t e;
        int   k;
        do_reset();
        build(n, ferr_cnt, ferr_pos, cs_xor);
        tx_busy = 1'b1;
        if (stop_words >= 0) begin
            while (stream.size() > 4 + 4 * stop_words) void'(stream.pop_back());
            send_stream();
            repeat (3) @(posedge clk);
            return;
        end
        send_stream();
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
        tx_busy = 1'b0;
        k = 0;
        while (k < 300 && tx_cnt == 0) begin
            @(negedge clk);
            k++;
        end
        check("tx_seen", tx_cnt, 1);
        @(posedge clk);
        #1;
        tx_busy = 1'b1;
        @(negedge clk);
        check("tx_hold", 32'(tx_data), 32'(exp_ack));
        check("err_flag", 32'(load_err), 32'(exp_err));
        check("done_high", 32'(load_done), 1);
        check("wr_left", expq.size(), 0);
        for (int j = 0; j < 3; j++) begin
            e.d = 8'($urandom); e.f = (j == 1); e.wr = 1'b0; e.addr = 0; e.wd = 32'd0;
            stream.push_back(e);
        end
        send_stream();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("done_ignore_err", 32'(load_err), 32'(exp_err));
        check("done_ignore_tx", tx_cnt, 1);
        check("done_stays", 32'(load_done), 1);
        #1;
        tx_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Two words into addresses 0 and 1
        wd[0] = 32'h11223344;
        wd[1] = 32'hDEADBEEF;
        run_load(2, 0, -1, 8'h00, -1);
        check("d2_writes", wr_cnt, 2);
        check("d2_first", first_wdata, 32'h11223344);
        check("d2_addr1", last_addr, 1);
        check("d2_data1", last_wdata, 32'hDEADBEEF);
        check("d2_ack", 32'(last_tx), 32'h000000AA);

        // Empty image
        run_load(0, 0, -1, 8'h00, -1);
        check("n0_writes", wr_cnt, 0);
        check("n0_ack", 32'(last_tx), 32'h000000AA);

        // Framing error inside the first word
        wd[0] = 32'hCAFEF00D;
        run_load(1, 1, 5, 8'h00, -1);
        check("ferr_writes", wr_cnt, 1);
        check("ferr_data", last_wdata, 32'hCAFEF00D);
        check("ferr_ack", 32'(last_tx), 32'h00000055);
        check("ferr_err", 32'(load_err), 1);

        // Overflow past 2**AW words
        for (int i = 0; i < 5; i++) wd[i] = $urandom;
        run_load(5, 0, -1, 8'h00, -1);
        check("ovf_writes", wr_cnt, 4);
        check("ovf_last_addr", last_addr, 3);
        check("ovf_ack", 32'(last_tx), 32'h00000055);

`ifdef UART_LOADER_CHKSUM_EN
        wd[0] = 32'h01020304;
        run_load(1, 0, -1, 8'h00, -1);
        check("cs_good_ack", 32'(last_tx), 32'h000000AA);
        run_load(1, 0, -1, 8'h04, -1);
        check("cs_bad_ack", 32'(last_tx), 32'h00000055);
        check("cs_bad_writes", wr_cnt, 1);
`endif

        // Abort after two of four words, then a clean reload
        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        run_load(4, 0, -1, 8'h00, 2);
        check("abort_writes", wr_cnt, 2);
        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        run_load(4, 0, -1, 8'h00, -1);
        check("reload_writes", wr_cnt, 4);
        check("reload_first_addr", first_addr, 0);
        check("reload_ack", 32'(last_tx), 32'h000000AA);

        // Randomized loads
        for (int t = 0; t < 12; t++) begin
            int          n;
            int          fe;
            logic [7:0]  cx;
            n = int'($urandom_range(0, 6));
            fe = ($urandom_range(0, 3) == 0) ? 1 : 0;
            cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            for (int i = 0; i < n; i++) wd[i] = $urandom;
            run_load(n, fe, -1, cx, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
